// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the data memory arbiter.
//   state_t    - sequencer states
//   mem_req_t  - one port's request operands
//   range_err  - byte-address range check for a DEPTH-byte memory
package dma_pkg;
   localparam int ADDR_W    = 16;
   localparam int DATA_W    = 16;
   localparam int MEM_DEPTH = 64;
   typedef enum logic [2:0] {IDLE, ISSUE, RMW_RD, RMW_WR, RESP} state_t;
   typedef struct packed {
      logic              we;
      logic              bw;
      logic              sx;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;
   // two_bytes: the access touches addr and addr+1 (word access, or the RMW of a byte store)
   function automatic logic range_err(input logic [ADDR_W-1:0] addr, input logic two_bytes,
                                      input int unsigned depth);
      return (32'(addr) >= depth) || (two_bytes && 32'(addr) == depth - 1);
   endfunction
endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: one requester port of the data memory arbiter.
//   req/we/bw/sx/addr/wdata : requester -> arbiter, held stable until ack
//   ack/err/rdata           : arbiter -> requester, err and rdata valid with ack
interface data_mem_arbiter_if;
   import dma_pkg::*;
   logic              req;
   logic              we;
   logic              bw;
   logic              sx;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic              err;
   logic [DATA_W-1:0] rdata;
   modport master (output req, we, bw, sx, addr, wdata, input ack, err, rdata);
   modport slave  (input req, we, bw, sx, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : request per port
//   accept_i     : grant is taken this cycle; the last-grant register moves only then
//   gnt_o        : one-hot grant (combinational)
module rr_arbiter2 #(
   parameter bit PRIO_INIT = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic [1:0] gnt_o
);
   logic last_q, last_d;
   always_comb begin
      gnt_o  = (&req_i) ? (last_q ? 2'b01 : 2'b10) : req_i;
      last_d = (accept_i && |req_i) ? gnt_o[1] : last_q;
   end
   // starting from ~PRIO_INIT makes PRIO_INIT win the first contention
   always_ff @(posedge clk_i) begin
      last_q <= rst_i ? ~PRIO_INIT : last_d;
   end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port sequencer in front of a single-port byte-addressed data memory.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   p0_if, p1_if     : CPU load/store port and loader port (req/ack handshake)
//   address_o        : memory byte address, holds its last value
//   write_data_o     : memory write data
//   mem_read_o       : memory read strobe (memory samples on negedge)
//   mem_write_o      : memory write strobe (memory writes on posedge)
//   ctrl_bw_o        : byte read
//   ctrl_m_o         : sign-extend byte read
//   data_i           : memory read data, valid at the posedge after mem_read_o
module data_mem_arbiter
   import dma_pkg::*;
#(
   parameter int unsigned DEPTH     = MEM_DEPTH,
   parameter bit          PRIO_INIT = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   data_mem_arbiter_if.slave    p0_if,
   data_mem_arbiter_if.slave    p1_if,
   output logic [ADDR_W-1:0]    address_o,
   output logic [DATA_W-1:0]    write_data_o,
   output logic                 mem_read_o,
   output logic                 mem_write_o,
   output logic                 ctrl_bw_o,
   output logic                 ctrl_m_o,
   input  logic [DATA_W-1:0]    data_i
);
   localparam int B = DATA_W / 2;
   state_t                   state_q, state_d;
   logic                     port_q, port_d;
   logic                     err_q, err_d;
   logic                     we_q, we_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic [DATA_W-1:0]        wdata_q, wdata_d;
   logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]               ack_q, ack_d;
   logic                     rd_q, rd_d, wr_q, wr_d, bw_q, bw_d, m_q, m_d;
   logic [DATA_W-1:0]        wd_q, wd_d;
   logic [1:0]               gnt;
   mem_req_t                 sel;
   logic                     sel_err;
   rr_arbiter2 #(.PRIO_INIT(PRIO_INIT)) u_arb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    ({p1_if.req, p0_if.req}),
      .accept_i (state_q == IDLE),
      .gnt_o    (gnt)
   );
   assign sel = gnt[1] ? {p1_if.we, p1_if.bw, p1_if.sx, p1_if.addr, p1_if.wdata}
                       : {p0_if.we, p0_if.bw, p0_if.sx, p0_if.addr, p0_if.wdata};
   // a byte store reads then writes the whole word, so it needs addr+1 in range too
   assign sel_err = range_err(sel.addr, !sel.bw || sel.we, DEPTH);
   always_comb begin
      state_d = state_q;
      port_d  = port_q;
      err_d   = err_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ack_d   = '0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      bw_d    = 1'b0;
      m_d     = 1'b0;
      wd_d    = '0;
      case (state_q)
         IDLE: if (|gnt) begin
            port_d  = gnt[1];
            err_d   = sel_err;
            we_d    = sel.we;
            addr_d  = sel.addr;
            wdata_d = sel.wdata;
            state_d = (!sel_err && sel.we && sel.bw) ? RMW_RD : ISSUE;
            rd_d    = !sel_err && (!sel.we || sel.bw);
            wr_d    = !sel_err && sel.we && !sel.bw;
            bw_d    = !sel_err && !sel.we && sel.bw;
            m_d     = bw_d && sel.sx;
            wd_d    = wr_d ? sel.wdata : '0;
         end
         ISSUE: begin
            state_d        = RESP;
            ack_d[port_q]  = 1'b1;
            if (err_q || !we_q) rdata_d[port_q] = err_q ? '0 : data_i;
         end
         RMW_RD: begin
            state_d = RMW_WR;
            wr_d    = 1'b1;
            wd_d    = {data_i[DATA_W-1:B], wdata_q[B-1:0]};
         end
         RMW_WR: begin
            state_d       = RESP;
            ack_d[port_q] = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         port_q  <= 1'b0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         bw_q    <= 1'b0;
         m_q     <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         err_q   <= err_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         bw_q    <= bw_d;
         m_q     <= m_d;
         wd_q    <= wd_d;
      end
   end
   assign address_o    = addr_q;
   assign write_data_o = wd_q;
   assign mem_read_o   = rd_q;
   assign mem_write_o  = wr_q;
   assign ctrl_bw_o    = bw_q;
   assign ctrl_m_o     = m_q;
   assign p0_if.ack    = ack_q[0];
   assign p1_if.ack    = ack_q[1];
   assign p0_if.err    = ack_q[0] & err_q;
   assign p1_if.err    = ack_q[1] & err_q;
   assign p0_if.rdata  = rdata_q[0];
   assign p1_if.rdata  = rdata_q[1];
endmodule
